// File: rtl/ps2_note_scheduler.sv
// PS/2 set-2 parser + monophonic voice scheduler; every output registers on the strobe edge (visible next cycle).
// No backpressure: each received_data_en strobe is consumed in its own cycle, including back-to-back strobes.
module ps2_note_scheduler #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic [7:0] held,
  output logic       active_valid,
  output logic [2:0] active_note,
  output logic       note_on,
  output logic       note_off,
  output logic [2:0] event_note,
  output logic       proto_err
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  localparam logic [7:0]       BRK_CODE = 8'hF0;
  localparam logic [7:0]       EXT_CODE = 8'hE0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             mapped;
  logic [2:0]       idx;
  logic [7:0]       held_rel;
  logic [2:0]       low_idx;

  always_comb begin
    mapped = 1'b1;
    idx    = 3'd0;
    case (received_data)
      8'h1C:   idx = 3'd0;
      8'h1B:   idx = 3'd1;
      8'h23:   idx = 3'd2;
      8'h2B:   idx = 3'd3;
      8'h34:   idx = 3'd4;
      8'h33:   idx = 3'd5;
      8'h3B:   idx = 3'd6;
      8'h42:   idx = 3'd7;
      default: mapped = 1'b0;
    endcase
  end

  // Held mask after releasing idx, and the fallback owner chosen from it.
  always_comb begin
    held_rel = held & ~(8'd1 << idx);
    low_idx  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (held_rel[i]) low_idx = 3'(i);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      held         <= 8'd0;
      active_valid <= 1'b0;
      active_note  <= 3'd0;
      note_on      <= 1'b0;
      note_off     <= 1'b0;
      event_note   <= 3'd0;
      proto_err    <= 1'b0;
    end else begin
      note_on   <= 1'b0;
      note_off  <= 1'b0;
      proto_err <= 1'b0;
      if (received_data_en) begin
        cnt <= '0;
        case (state)
          IDLE: begin
            if (received_data == BRK_CODE) begin
              state <= BRK;
            end else if (received_data == EXT_CODE) begin
              state <= EXT;
            end else if (mapped && !held[idx]) begin
              held[idx]    <= 1'b1;
              active_valid <= 1'b1;
              active_note  <= idx;
              note_on      <= 1'b1;
              event_note   <= idx;
            end
          end
          BRK: begin
            state <= IDLE;
            if (received_data == BRK_CODE || received_data == EXT_CODE) begin
              proto_err <= 1'b1;
            end else if (mapped && held[idx]) begin
              held <= held_rel;
              if (active_valid && active_note == idx) begin
                if (|held_rel) begin
                  active_note <= low_idx;
                  note_on     <= 1'b1;
                  event_note  <= low_idx;
                end else begin
                  active_valid <= 1'b0;
                  note_off     <= 1'b1;
                  event_note   <= idx;
                end
              end
            end
          end
          EXT:     state <= (received_data == BRK_CODE) ? EXT_BRK : IDLE;
          EXT_BRK: state <= IDLE;
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // A strobe in the expiry cycle takes the branch above, so the byte wins.
        if (cnt == CNT_LAST) begin
          state     <= IDLE;
          cnt       <= '0;
          proto_err <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_note_scheduler.sv
// Bench for ps2_note_scheduler: directed scan-code sequences plus random byte streams against a key-set model.
module tb_ps2_note_scheduler;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rd = 8'd0;
  logic       en = 1'b0;
  logic [7:0] held;
  logic       active_valid;
  logic [2:0] active_note;
  logic       note_on;
  logic       note_off;
  logic [2:0] event_note;
  logic       proto_err;

  ps2_note_scheduler #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .CLOCK_50(clk), .resetn(rst_n), .received_data(rd), .received_data_en(en),
    .held(held), .active_valid(active_valid), .active_note(active_note),
    .note_on(note_on), .note_off(note_off), .event_note(event_note), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int cmp = 0;
  int mis = 0;

  // Model: set of held keys, owner of the voice (-1 = silent), pending prefix, idle count.
  bit [7:0]   m_held;
  int         m_act;
  int         m_pre;
  int         m_idle;
  bit         e_on, e_off, e_perr;
  bit [2:0]   e_ev;
  logic [7:0] codes [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};

  function automatic int key_of(logic [7:0] b);
    for (int i = 0; i < 8; i++) if (codes[i] == b) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_held = 8'd0; m_act = -1; m_pre = 0; m_idle = 0;
    e_on = 0; e_off = 0; e_perr = 0; e_ev = 3'd0;
  endtask

  task automatic model_byte(logic [7:0] b);
    int k;
    k = key_of(b);
    e_on = 0; e_off = 0; e_perr = 0; m_idle = 0;
    case (m_pre)
      0: begin
        if (b == 8'hF0) m_pre = 1;
        else if (b == 8'hE0) m_pre = 2;
        else if (k >= 0 && !m_held[k]) begin
          m_held[k] = 1'b1; m_act = k; e_on = 1; e_ev = 3'(k);
        end
      end
      1: begin
        m_pre = 0;
        if (b == 8'hF0 || b == 8'hE0) e_perr = 1;
        else if (k >= 0 && m_held[k]) begin
          m_held[k] = 1'b0;
          if (m_act == k) begin
            if (m_held != 0) begin
              for (int i = 0; i < 8; i++) if (m_held[i]) begin m_act = i; break; end
              e_on = 1; e_ev = 3'(m_act);
            end else begin
              m_act = -1; e_off = 1; e_ev = 3'(k);
            end
          end
        end
      end
      2: m_pre = (b == 8'hF0) ? 3 : 0;
      default: m_pre = 0;
    endcase
  endtask

  task automatic model_idle();
    e_on = 0; e_off = 0; e_perr = 0;
    if (m_pre != 0) begin
      m_idle++;
      if (m_idle == TO) begin m_pre = 0; m_idle = 0; e_perr = 1; end
    end
  endtask

  function automatic logic [17:0] obs_vec();
    return {held, active_valid, active_valid ? active_note : 3'd0, note_on, note_off,
            (note_on | note_off) ? event_note : 3'd0, proto_err};
  endfunction

  function automatic logic [17:0] exp_vec();
    return {m_held, m_act >= 0, (m_act >= 0) ? 3'(m_act) : 3'd0, e_on, e_off,
            (e_on | e_off) ? e_ev : 3'd0, e_perr};
  endfunction

  task automatic send_byte(logic [7:0] b);
    @(negedge clk); rd = b; en = 1'b1;
    @(posedge clk); #1;
    model_byte(b);
  endtask

  task automatic idle1();
    @(negedge clk); en = 1'b0; rd = 8'($urandom);
    @(posedge clk); #1;
    model_idle();
  endtask

  task automatic run_seq(string name, logic [7:0] seq [$]);
    foreach (seq[k]) begin
      send_byte(seq[k]);
      cmp++;
      if (obs_vec() !== exp_vec()) begin
        mis++; $display("FAIL %s byte %0d (%h): got %h want %h", name, k, seq[k], obs_vec(), exp_vec());
      end
      idle1();
      cmp++;
      if (obs_vec() !== exp_vec()) begin
        mis++; $display("FAIL %s idle after %0d: got %h want %h", name, k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    cmp++;
    if (obs_vec() !== 18'd0 || event_note !== 3'd0 || active_note !== 3'd0) begin
      mis++; $display("FAIL reset_state: got %h/%0d/%0d want 0", obs_vec(), event_note, active_note);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    send_byte(8'h1C);
    cmp++;
    if (held !== 8'h01 || !note_on || event_note !== 3'd0 || !active_valid) begin
      mis++; $display("FAIL basic_make: got held %h on %b ev %0d want 01 1 0", held, note_on, event_note);
    end
    idle1();
    run_seq("basic_release", '{8'hF0, 8'h1C});
    cmp++;
    if (held !== 8'h00 || active_valid !== 1'b0) begin
      mis++; $display("FAIL basic_final: got held %h valid %b want 00 0", held, active_valid);
    end
  endtask

  task automatic test_fallback();
    logic [7:0] seq [6] = '{8'h1C, 8'h23, 8'hF0, 8'h23, 8'hF0, 8'h1C};
    logic [3:0] want_ev [6] = '{4'h8, 4'hA, 4'h0, 4'h8, 4'h0, 4'h0};
    foreach (seq[k]) begin
      send_byte(seq[k]);
      cmp++;
      if (obs_vec() !== exp_vec()) begin
        mis++; $display("FAIL fallback byte %0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      if (want_ev[k][3]) begin
        cmp++;
        if (note_on !== 1'b1 || event_note !== want_ev[k][2:0]) begin
          mis++; $display("FAIL fallback_on %0d: got on %b ev %0d want 1 %0d", k, note_on, event_note, want_ev[k][2:0]);
        end
      end
      idle1();
    end
  endtask

  task automatic test_typematic();
    run_seq("typematic", '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h2B, 8'hF0, 8'h1C});
  endtask

  task automatic test_extended();
    run_seq("extended", '{8'hE0, 8'h1C, 8'hE0, 8'hF0, 8'h1C, 8'h1B, 8'hF0, 8'h1B});
  endtask

  task automatic test_proto_err();
    run_seq("proto", '{8'hF0, 8'hF0, 8'h1C, 8'hF0, 8'hE0, 8'hF0, 8'h1C});
  endtask

  task automatic test_timeout();
    send_byte(8'hF0);
    for (int i = 0; i < TO; i++) begin
      idle1();
      cmp++;
      if (obs_vec() !== exp_vec()) begin
        mis++; $display("FAIL timeout idle %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    send_byte(8'h1C);
    cmp++;
    if (held !== 8'h01 || note_on !== 1'b1) begin
      mis++; $display("FAIL timeout_make: got held %h on %b want 01 1", held, note_on);
    end
    // One cycle short of expiry: the break must still land.
    send_byte(8'hF0);
    repeat (TO - 1) idle1();
    cmp++;
    if (proto_err !== 1'b0) begin
      mis++; $display("FAIL timeout_early: got proto_err %b want 0", proto_err);
    end
    send_byte(8'h1C);
    cmp++;
    if (obs_vec() !== exp_vec() || note_off !== 1'b1) begin
      mis++; $display("FAIL timeout_edge_break: got %h want %h", obs_vec(), exp_vec());
    end
    idle1();
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    int gap;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: b = codes[$urandom_range(0, 7)];
        6, 7:             b = 8'hF0;
        8:                b = 8'hE0;
        default:          b = 8'($urandom);
      endcase
      send_byte(b);
      cmp++;
      if (obs_vec() !== exp_vec()) begin
        mis++; $display("FAIL random byte %0d (%h): got %h want %h", n, b, obs_vec(), exp_vec());
      end
      gap = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 20) : 0;
      for (int g = 0; g < gap; g++) begin
        idle1();
        cmp++;
        if (obs_vec() !== exp_vec()) begin
          mis++; $display("FAIL random idle %0d/%0d: got %h want %h", n, g, obs_vec(), exp_vec());
        end
      end
    end
    idle1();
  endtask

  task automatic test_reset_mid();
    model_reset();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    run_seq("reset_mid_setup", '{8'h1C, 8'h34});
    send_byte(8'hF0);
    @(negedge clk); en = 1'b0; #2;
    rst_n = 1'b0; #1;
    cmp++;
    if (obs_vec() !== 18'd0) begin
      mis++; $display("FAIL reset_mid_async: got %h want 0", obs_vec());
    end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    send_byte(8'h1C);
    cmp++;
    if (obs_vec() !== exp_vec() || held !== 8'h01 || note_on !== 1'b1) begin
      mis++; $display("FAIL reset_mid_make: got %h want %h", obs_vec(), exp_vec());
    end
    idle1();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fallback();
    test_typematic();
    test_extended();
    test_proto_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
